// File: rtl/dht11_temperature_reader_if.sv
// DHT11 reader bus: sensor line sample, open-drain enable and the decoded
// measurement/status outputs.
//   dht_in      : sensor line as seen at the pad (asynchronous)
//   dht_oe      : 1 = pull the line low, 0 = release to the pull-up
//   temperature : {integral, decimal} bytes, feeds the PIO in_port
//   humidity    : {integral, decimal} bytes
//   valid       : sticky, set by the first good frame
//   crc_err     : one-cycle pulse on checksum mismatch
//   timeout_err : one-cycle pulse on a wait-for-edge timeout
//   busy        : high whenever a transaction is in progress
// master = the reader, slave = the pad / system side.
interface dht11_temperature_reader_if;
   logic        dht_in;
   logic        dht_oe;
   logic [15:0] temperature;
   logic [15:0] humidity;
   logic        valid;
   logic        crc_err;
   logic        timeout_err;
   logic        busy;

   modport master (
      input  dht_in,
      output dht_oe,
      output temperature,
      output humidity,
      output valid,
      output crc_err,
      output timeout_err,
      output busy
   );

   modport slave (
      output dht_in,
      input  dht_oe,
      input  temperature,
      input  humidity,
      input  valid,
      input  crc_err,
      input  timeout_err,
      input  busy
   );
endinterface

// File: rtl/dht11_temperature_reader.sv
// Periodic DHT11 single-wire reader. Issues the host start pulse, times the
// sensor response and 40 data bits in microseconds, checks the checksum and
// registers temperature/humidity on a good frame.
//   clk   : system clock (CLK_FREQ_HZ, integer multiple of 1 MHz)
//   reset : synchronous, active-high
//   bus   : dht11_temperature_reader_if.master (line I/O and results)
module dht11_temperature_reader #(
   parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
   parameter int unsigned POLL_US       = 1_000_000,
   parameter int unsigned START_LOW_US  = 18_000,
   parameter int unsigned TIMEOUT_US    = 200,
   parameter int unsigned BIT_THRESH_US = 50
) (
   input logic                           clk,
   input logic                           reset,
   dht11_temperature_reader_if.master    bus
);

   localparam int unsigned DIV    = CLK_FREQ_HZ / 1_000_000;
   localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned DUR_W  = 21;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned FRAME_W = 40;

   typedef enum logic [2:0] {
      IDLE,
      START,
      RELEASE,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      CHECK
   } state_t;

   state_t             state;
   logic [PRE_W-1:0]   pre_cnt;
   logic               us_tick;
   logic [DUR_W-1:0]   dur;
   logic [CNT_W-1:0]   bit_cnt;
   logic [FRAME_W-1:0] shift;
   logic               sync1;
   logic               sync2;
   logic               prev;

   logic               rise;
   logic               fall;
   logic               timed_out;
   logic [DUR_W-1:0]   dur_meas;
   logic               bit_val;
   logic [7:0]         b0, b1, b2, b3, b4;
   logic [7:0]         sum;

   // Free-running microsecond prescaler.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt <= '0;
         us_tick <= 1'b0;
      end else if (pre_cnt == PRE_W'(DIV - 1)) begin
         pre_cnt <= '0;
         us_tick <= 1'b1;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
         us_tick <= 1'b0;
      end
   end

   // Two-flop synchronizer plus previous sample for edge detection.
   // Idle line is pulled high, so reset to 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= bus.dht_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise      = sync2 & ~prev;
   assign fall      = ~sync2 & prev;
   assign timed_out = (dur >= DUR_W'(TIMEOUT_US));

   // Include the tick coinciding with the falling edge so a high pulse of
   // N microseconds measures exactly N regardless of prescaler phase.
   assign dur_meas = dur + DUR_W'(us_tick);
   assign bit_val  = (dur_meas >= DUR_W'(BIT_THRESH_US));

   assign b0  = shift[39:32];
   assign b1  = shift[31:24];
   assign b2  = shift[23:16];
   assign b3  = shift[15:8];
   assign b4  = shift[7:0];
   assign sum = b0 + b1 + b2 + b3;

   // Transaction FSM; every transition clears dur, error pulses last one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         dur             <= '0;
         bit_cnt         <= '0;
         shift           <= '0;
         bus.dht_oe      <= 1'b0;
         bus.temperature <= '0;
         bus.humidity    <= '0;
         bus.valid       <= 1'b0;
         bus.crc_err     <= 1'b0;
         bus.timeout_err <= 1'b0;
         bus.busy        <= 1'b0;
      end else begin
         bus.crc_err     <= 1'b0;
         bus.timeout_err <= 1'b0;
         if (us_tick) begin
            dur <= dur + DUR_W'(1);
         end

         case (state)
            IDLE: begin
               if (us_tick && (dur == DUR_W'(POLL_US - 1))) begin
                  state      <= START;
                  dur        <= '0;
                  bus.dht_oe <= 1'b1;
                  bus.busy   <= 1'b1;
               end
            end

            START: begin
               if (us_tick && (dur == DUR_W'(START_LOW_US - 1))) begin
                  state      <= RELEASE;
                  dur        <= '0;
                  bus.dht_oe <= 1'b0;
               end
            end

            RELEASE: begin
               if (fall) begin
                  state <= RESP_LOW;
                  dur   <= '0;
               end else if (timed_out) begin
                  state           <= IDLE;
                  dur             <= '0;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end
            end

            RESP_LOW: begin
               if (rise) begin
                  state <= RESP_HIGH;
                  dur   <= '0;
               end else if (timed_out) begin
                  state           <= IDLE;
                  dur             <= '0;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end
            end

            RESP_HIGH: begin
               if (fall) begin
                  state   <= BIT_LOW;
                  dur     <= '0;
                  bit_cnt <= '0;
               end else if (timed_out) begin
                  state           <= IDLE;
                  dur             <= '0;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end
            end

            BIT_LOW: begin
               if (rise) begin
                  state <= BIT_HIGH;
                  dur   <= '0;
               end else if (timed_out) begin
                  state           <= IDLE;
                  dur             <= '0;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end
            end

            BIT_HIGH: begin
               if (fall) begin
                  shift   <= {shift[FRAME_W-2:0], bit_val};
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  dur     <= '0;
                  if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                     state <= CHECK;
                  end else begin
                     state <= BIT_LOW;
                  end
               end else if (timed_out) begin
                  state           <= IDLE;
                  dur             <= '0;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= 1'b1;
               end
            end

            CHECK: begin
               state    <= IDLE;
               dur      <= '0;
               bus.busy <= 1'b0;
               if (sum == b4) begin
                  bus.humidity    <= {b0, b1};
                  bus.temperature <= {b2, b3};
                  bus.valid       <= 1'b1;
               end else begin
                  bus.crc_err <= 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               dur      <= '0;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
